// File: rtl/seq_div8_if.sv
// Operand/result bundle for the sequential divider; master drives requests, slave is the divider.
interface seq_div8_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_div8.sv
// Sequential restoring divider, one quotient bit per clock, results held until the next done.
// Define DIV_SIGNED_EN for two's complement operands (truncating division).
module seq_div8 #(
   parameter int unsigned WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   seq_div8_if.slave  bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic {StIdle, StCalc} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remd_q, remd_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH+1:0] trial_sum;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quot_raw;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] quot_fix, rem_fix;
   logic             unused_trial_msb;

   // Trial subtract as add of inverted divisor with carry-in; carry out means no borrow.
   assign r_shift          = {rem_q, dvd_q[WIDTH-1]};
   assign trial_sum        = {1'b0, r_shift} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
   assign no_borrow        = trial_sum[WIDTH+1];
   assign rem_next         = no_borrow ? trial_sum[WIDTH-1:0] : r_shift[WIDTH-1:0];
   assign quot_raw         = {dvd_q[WIDTH-2:0], no_borrow};
   assign unused_trial_msb = trial_sum[WIDTH];

`ifdef DIV_SIGNED_EN
   logic a_neg, b_neg;
   logic negq_q, negq_d;
   logic negr_q, negr_d;

   assign a_neg    = bus.dividend[WIDTH-1];
   assign b_neg    = bus.divisor[WIDTH-1];
   assign a_mag    = a_neg ? -bus.dividend : bus.dividend;
   assign b_mag    = b_neg ? -bus.divisor : bus.divisor;
   assign quot_fix = negq_q ? -quot_raw : quot_raw;
   assign rem_fix  = negr_q ? -rem_next : rem_next;

   always_comb begin
      negq_d = negq_q;
      negr_d = negr_q;
      if (state_q == StIdle && bus.start) begin
         negq_d = a_neg ^ b_neg;
         negr_d = a_neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end
`else
   assign a_mag    = bus.dividend;
   assign b_mag    = bus.divisor;
   assign quot_fix = quot_raw;
   assign rem_fix  = rem_next;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      remd_d  = remd_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  done_d = 1'b1;
                  dbz_d  = 1'b1;
                  quot_d = '1;
                  remd_d = bus.dividend;
               end else begin
                  dvd_d   = a_mag;
                  dvs_d   = b_mag;
                  rem_d   = '0;
                  cnt_d   = CntW'(WIDTH - 1);
                  busy_d  = 1'b1;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rem_d = rem_next;
            dvd_d = quot_raw;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quot_d  = quot_fix;
               remd_d  = rem_fix;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         remd_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         remd_q  <= remd_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = remd_q;
   assign bus.div_by_zero = dbz_q;
endmodule
